// File: rtl/mem_stage_if.sv
// Memory-stage bus: the execute stage's request/payload and the MEM/WB
// payload plus the stall request back upstream.
//   master : driven by the upstream pipeline (EXE/MEM register side)
//   slave  : the memory stage itself
// Requests : MEM_R_EN, MEM_W_EN, ALU_result (address or pass-through),
//            Val_Rm (store data), WB_EN, Dest
// Responses: freeze (combinational stall), WB_EN_out, MEM_R_EN_out,
//            Dest_out, ALU_result_out, MEM_result (all registered except freeze)
interface mem_stage_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_result;
  logic [31:0] Val_Rm;
  logic        WB_EN;
  logic [3:0]  Dest;
  logic        freeze;
  logic        WB_EN_out;
  logic        MEM_R_EN_out;
  logic [3:0]  Dest_out;
  logic [31:0] ALU_result_out;
  logic [31:0] MEM_result;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm, WB_EN, Dest,
    input  freeze, WB_EN_out, MEM_R_EN_out, Dest_out, ALU_result_out, MEM_result
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm, WB_EN, Dest,
    output freeze, WB_EN_out, MEM_R_EN_out, Dest_out, ALU_result_out, MEM_result
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the five-stage ARM pipeline.
// Performs loads/stores against an internal word-addressed data memory with
// WAIT_STATES extra cycles per access, registers the MEM/WB payload and
// raises freeze to stall upstream while a multi-cycle access is in flight.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_stage_if.slave (request inputs, MEM/WB payload outputs, freeze)
module mem_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];

  // Request captured at the start of a multi-cycle access
  logic [AW-1:0]   r_l_idx;
  logic [31:0]     r_l_wdata;
  logic [31:0]     r_l_alu;
  logic            r_l_wb;
  logic [3:0]      r_l_dest;
  logic            r_l_store;
  logic            r_l_load;

  // MEM/WB payload
  logic            r_wb_out;
  logic            r_rd_out;
  logic [3:0]      r_dest_out;
  logic [31:0]     r_alu_out;
  logic [31:0]     r_mem_res;

  logic            w_req;
  logic            w_busy;
  logic            w_freeze;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_c_idx;
  logic [31:0]     w_c_wdata;
  logic [31:0]     w_c_alu;
  logic            w_c_wb;
  logic [3:0]      w_c_dest;
  logic            w_c_store;
  logic            w_c_load;
  logic            w_we;

  assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_busy = (r_state == BUSY);
  // Rebase to word 0, drop byte offset, wrap to the memory depth
  assign w_idx  = AW'((bus.ALU_result - 32'(BASE_ADDR)) >> 2);

  // Stall: starting a wait-stated access, or still short of the final cycle.
  // Forced low during reset so upstream is released immediately.
  always_comb begin
    w_freeze = 1'b0;
    if (rst) begin
      if (r_state == IDLE) w_freeze = w_req && (WS != 4'd0);
      else                 w_freeze = (r_cnt != WS);
    end
  end
  assign bus.freeze = w_freeze;

  // The committing access comes from the latch when finishing a multi-cycle
  // access, otherwise straight from the inputs. A store wins over a load.
  assign w_c_idx   = w_busy ? r_l_idx   : w_idx;
  assign w_c_wdata = w_busy ? r_l_wdata : bus.Val_Rm;
  assign w_c_alu   = w_busy ? r_l_alu   : bus.ALU_result;
  assign w_c_wb    = w_busy ? r_l_wb    : bus.WB_EN;
  assign w_c_dest  = w_busy ? r_l_dest  : bus.Dest;
  assign w_c_store = w_busy ? r_l_store : bus.MEM_W_EN;
  assign w_c_load  = w_busy ? r_l_load  : (bus.MEM_R_EN & ~bus.MEM_W_EN);

  // Gated by rst so a store interrupted by reset is never written
  assign w_we = rst & ~w_freeze & w_c_store;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_c_idx] <= w_c_wdata;
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_freeze) begin
      r_l_idx   <= w_idx;
      r_l_wdata <= bus.Val_Rm;
      r_l_alu   <= bus.ALU_result;
      r_l_wb    <= bus.WB_EN;
      r_l_dest  <= bus.Dest;
      r_l_store <= bus.MEM_W_EN;
      r_l_load  <= bus.MEM_R_EN & ~bus.MEM_W_EN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_wb_out   <= 1'b0;
      r_rd_out   <= 1'b0;
      r_dest_out <= 4'd0;
      r_alu_out  <= 32'd0;
      r_mem_res  <= 32'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_freeze) begin
            r_state <= BUSY;
            r_cnt   <= 4'd1;
          end
        end
        BUSY: begin
          if (r_cnt != WS) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end
        end
      endcase

      // Stalled cycles emit a bubble; other fields hold
      if (w_freeze) begin
        r_wb_out <= 1'b0;
        r_rd_out <= 1'b0;
      end else begin
        r_wb_out   <= w_c_wb;
        r_rd_out   <= w_c_load;
        r_dest_out <= w_c_dest;
        r_alu_out  <= w_c_alu;
        if (w_c_load) r_mem_res <= r_mem[w_c_idx];
      end
    end
  end

  assign bus.WB_EN_out      = r_wb_out;
  assign bus.MEM_R_EN_out   = r_rd_out;
  assign bus.Dest_out       = r_dest_out;
  assign bus.ALU_result_out = r_alu_out;
  assign bus.MEM_result     = r_mem_res;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if if2 ();
  mem_stage_if if0 ();

  mem_stage #(.DEPTH_WORDS(64), .BASE_ADDR(1024), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );
  mem_stage #(.DEPTH_WORDS(64), .BASE_ADDR(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] val;
    logic        wb;
    logic [3:0]  dest;
    logic        e_wb;
    logic        e_rd;
    logic [3:0]  e_dest;
    logic [31:0] e_alu;
    logic [31:0] e_mem;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] val, input logic wb, input logic [3:0] dest);
    if2.MEM_R_EN = rd; if2.MEM_W_EN = wr; if2.ALU_result = alu;
    if2.Val_Rm = val;  if2.WB_EN = wb;    if2.Dest = dest;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] val, input logic wb, input logic [3:0] dest);
    if0.MEM_R_EN = rd; if0.MEM_W_EN = wr; if0.ALU_result = alu;
    if0.Val_Rm = val;  if0.WB_EN = wb;    if0.Dest = dest;
  endtask

  task automatic out2(input string tag, input logic wb, input logic rd, input logic [3:0] dest,
                      input logic [31:0] alu, input logic [31:0] mres);
    chk({tag, "_wb"},   32'(if2.WB_EN_out),    32'(wb));
    chk({tag, "_rd"},   32'(if2.MEM_R_EN_out), 32'(rd));
    chk({tag, "_dest"}, 32'(if2.Dest_out),     32'(dest));
    chk({tag, "_alu"},  if2.ALU_result_out,    alu);
    chk({tag, "_mres"}, if2.MEM_result,        mres);
  endtask

  // Full wait-stated access on the WS=2 instance: freeze high, high, low
  task automatic acc2(input logic rd, input logic wr, input logic [31:0] alu,
                      input logic [31:0] val, input logic wb, input logic [3:0] dest);
    drive2(rd, wr, alu, val, wb, dest);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("acc2_freeze_c%0d", k), 32'(if2.freeze), (k < 2) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'd1024, 32'd1,    1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd1024, 32'd0};
    vt[1]  = '{1'b0, 1'b1, 32'd1032, 32'd2,    1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd1032, 32'd0};
    vt[2]  = '{1'b1, 1'b0, 32'd1024, 32'd0,    1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 32'd1024, 32'd1};
    vt[3]  = '{1'b1, 1'b0, 32'd1032, 32'd0,    1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 32'd1032, 32'd2};
    vt[4]  = '{1'b0, 1'b0, 32'h55,   32'd0,    1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 32'h55,   32'd2};
    vt[5]  = '{1'b0, 1'b1, 32'd1280, 32'd7,    1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd1280, 32'd2};
    vt[6]  = '{1'b0, 1'b1, 32'd1027, 32'd9,    1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd1027, 32'd2};
    vt[7]  = '{1'b1, 1'b0, 32'd1024, 32'd0,    1'b1, 4'd4, 1'b1, 1'b1, 4'd4, 32'd1024, 32'd9};
    vt[8]  = '{1'b1, 1'b1, 32'd1040, 32'h12,   1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd1040, 32'd9};
    vt[9]  = '{1'b1, 1'b0, 32'd1040, 32'd0,    1'b1, 4'd6, 1'b1, 1'b1, 4'd6, 32'd1040, 32'h12};
    vt[10] = '{1'b0, 1'b1, 32'd1036, 32'h33,   1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd1036, 32'h12};
    vt[11] = '{1'b1, 1'b0, 32'd1036, 32'd0,    1'b1, 4'd8, 1'b1, 1'b1, 4'd8, 32'd1036, 32'h33};

    // Reset held with live inputs, including a pending request
    rst = 1'b0;
    drive2(1'b0, 1'b1, 32'd1028, 32'd5, 1'b1, 4'd3);
    drive0(1'b0, 1'b0, 32'h55, 32'd0, 1'b1, 4'd3);
    repeat (3) tick();
    chk("rst_freeze2", 32'(if2.freeze), 32'd0);
    chk("rst_freeze0", 32'(if0.freeze), 32'd0);
    out2("rst", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("rst_alu0", if0.ALU_result_out, 32'd0);

    // Release: non-memory pass-through with one-cycle latency
    drive2(1'b0, 1'b0, 32'h55, 32'd0, 1'b1, 4'd3);
    rst = 1'b1;
    #1;
    chk("pass_freeze", 32'(if2.freeze), 32'd0);
    tick();
    out2("pass", 1'b1, 1'b0, 4'd3, 32'h55, 32'd0);

    // WS=2 store 0xDEADBEEF @1028
    drive2(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 4'd0);
    #1;
    chk("st_freeze_c0", 32'(if2.freeze), 32'd1);
    tick();
    out2("st_bubble", 1'b0, 1'b0, 4'd3, 32'h55, 32'd0);
    chk("st_freeze_c1", 32'(if2.freeze), 32'd1);
    tick();
    chk("st_freeze_c2", 32'(if2.freeze), 32'd0);
    tick();
    out2("st_commit", 1'b0, 1'b0, 4'd0, 32'd1028, 32'd0);

    // Back-to-back load @1028, Dest=5
    drive2(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 4'd5);
    #1;
    chk("ld_freeze_c0", 32'(if2.freeze), 32'd1);
    tick();
    out2("ld_bubble", 1'b0, 1'b0, 4'd0, 32'd1028, 32'd0);
    chk("ld_freeze_c1", 32'(if2.freeze), 32'd1);
    tick();
    chk("ld_freeze_c2", 32'(if2.freeze), 32'd0);
    tick();
    out2("ld_commit", 1'b1, 1'b1, 4'd5, 32'd1028, 32'hDEADBEEF);

    // Non-load keeps MEM_result
    drive2(1'b0, 1'b0, 32'h77, 32'd0, 1'b1, 4'd2);
    #1;
    chk("nm_freeze", 32'(if2.freeze), 32'd0);
    tick();
    out2("nm", 1'b1, 1'b0, 4'd2, 32'h77, 32'hDEADBEEF);

    // Reset in the second freeze cycle of a store
    acc2(1'b0, 1'b1, 32'd1044, 32'h11, 1'b0, 4'd0);
    drive2(1'b0, 1'b1, 32'd1044, 32'hAA, 1'b0, 4'd0);
    #1;
    chk("rm_freeze_c0", 32'(if2.freeze), 32'd1);
    tick();
    chk("rm_freeze_c1", 32'(if2.freeze), 32'd1);
    rst = 1'b0;
    #1;
    chk("rm_freeze_rst", 32'(if2.freeze), 32'd0);
    out2("rm_rst", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();
    drive2(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    drive0(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    rst = 1'b1;
    acc2(1'b1, 1'b0, 32'd1044, 32'd0, 1'b1, 4'd7);
    out2("rm_load", 1'b1, 1'b1, 4'd7, 32'd1044, 32'h11);
    drive2(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);

    // WS=0 table: single-cycle accesses, no freeze
    for (int i = 0; i < 12; i++) begin
      drive0(vt[i].rd, vt[i].wr, vt[i].alu, vt[i].val, vt[i].wb, vt[i].dest);
      #1;
      chk($sformatf("v%0d_freeze", i), 32'(if0.freeze), 32'd0);
      tick();
      chk($sformatf("v%0d_wb", i),   32'(if0.WB_EN_out),    32'(vt[i].e_wb));
      chk($sformatf("v%0d_rd", i),   32'(if0.MEM_R_EN_out), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_dest", i), 32'(if0.Dest_out),     32'(vt[i].e_dest));
      chk($sformatf("v%0d_alu", i),  if0.ALU_result_out,    vt[i].e_alu);
      chk($sformatf("v%0d_mres", i), if0.MEM_result,        vt[i].e_mem);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage ARM pipeline. It accepts the execute stage's ALU result (used as the address), the store operand and the memory read/write enables. It performs the access against an internal word-addressed data memory with a configurable number of wait states. It registers the MEM/WB payload and drives `freeze` to stall every upstream stage while a multi-cycle access is in flight.

## Interface
- `DEPTH_WORDS`, 64: data memory depth in 32-bit words; power of two.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_STATES`, 2: extra cycles per access; legal range 0..15. 0 gives single-cycle access.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_R_EN`  in  1  load request.
- `MEM_W_EN`  in  1  store request.
- `ALU_result`  in  32  byte address, or pass-through result for non-memory instructions.
- `Val_Rm`  in  32  store data.
- `WB_EN`  in  1  write-back enable of the current instruction.
- `Dest`  in  4  destination register number.
- `freeze`  out  1  combinational stall request to IF/ID/EXE and their pipeline registers.
- `WB_EN_out`  out  1  registered write-back enable.
- `MEM_R_EN_out`  out  1  registered load flag; the WB mux select.
- `Dest_out`  out  4  registered destination.
- `ALU_result_out`  out  32  registered pass-through ALU result.
- `MEM_result`  out  32  registered load data.

## Operation
- Word index = (`ALU_result` − `BASE_ADDR`) >> 2, truncated to log2(`DEPTH_WORDS`) bits.
  - Out-of-range addresses wrap.
  - Byte offset bits [1:0] are ignored.
- Request = `MEM_R_EN` | `MEM_W_EN`. When both are high, the access is a store and `MEM_R_EN_out` is registered 0.
- FSM states: IDLE, BUSY; cycle counter `cnt` (4 bits).
  - IDLE, no request: no stall; the payload registers load every cycle.
  - IDLE, request, `WAIT_STATES`=0: the access commits at this edge and the payload registers load. State stays IDLE.
  - IDLE, request, `WAIT_STATES`>0: `freeze`=1. Latch the index, store data, WB_EN, Dest, R/W kind and ALU result. Set `cnt`←1 and move to BUSY.
  - BUSY, `cnt`<`WAIT_STATES`: `freeze`=1, `cnt`←`cnt`+1.
  - BUSY, `cnt`=`WAIT_STATES`: `freeze`=0.
    - Commit the latched store to memory, or capture the read word into `MEM_result`.
    - Load the payload registers from the latched values and return to IDLE.
- Memory accesses use the latched request only. Upstream holds its inputs while `freeze` is high, but this block does not depend on that.
- While `freeze`=1, the payload registers are loaded with a bubble: `WB_EN_out`=0, `MEM_R_EN_out`=0, other fields hold.
- For non-load instructions, `MEM_result` holds its previous value.
- Memory contents are not reset.
- Reset (`rst`=0, asynchronous), including mid-access:
  - state←IDLE, `cnt`←0.
  - All registered outputs go to 0 and `freeze`=0 immediately.
  - A pending store is discarded, not committed.

## Timing
- Every access occupies `WAIT_STATES`+1 cycles. `freeze` is high for the first `WAIT_STATES` of them and low in the final one.
- The store write and the load capture happen on the rising edge that ends the final cycle. Load data is visible on `MEM_result` the next cycle, together with `MEM_R_EN_out`=1.
- `freeze` is combinational from state, `cnt`, `MEM_R_EN` and `MEM_W_EN`. It has no path from memory data.
- Back-to-back accesses: the cycle after a commit, IDLE evaluates the next request. There is no dead cycle beyond the wait states.
- A read of the address written by the immediately preceding store returns the new data.
- Non-memory instructions pass through with 1-cycle latency and never raise `freeze`.

## Test plan
- Reset, then hold `rst`=0 for 3 cycles → all outputs 0, `freeze`=0. Release → a non-memory instruction (`ALU_result`=0x55, `WB_EN`=1, `Dest`=3) appears on the outputs one cycle later.
- `WAIT_STATES`=2: store 0xDEADBEEF at address 1028, then load from 1028 (`Dest`=5) → for each access, `freeze` is high for 2 cycles then low for 1. The load is followed by `MEM_result`=0xDEADBEEF, `MEM_R_EN_out`=1, `Dest_out`=5. Bubble cycles show `WB_EN_out`=0.
- `WAIT_STATES`=0: back-to-back stores to 1024 and 1032 of 1 and 2, then loads of both → `freeze` never asserts; the reads return 1 and 2 on consecutive cycles.
- Wrap and alignment, `DEPTH_WORDS`=64: store 7 at 1024+256 and 9 at 1027 → a load of 1024 returns 9 (1024+256 wraps to word 0 and is overwritten by the later store).
- Both enables high with `Val_Rm`=0x12 at 1040 → treated as a store; `MEM_R_EN_out`=0. A subsequent load of 1040 returns 0x12.
- Assert `rst` in the second freeze cycle of a store of 0xAA to 1044, after first storing 0x11 there → `freeze` drops immediately and outputs go to 0. A post-reset load of 1044 returns 0x11.
